qspi_owner_arbiter: RTL
=======================

# qspi_owner_arbiter

Arbitrates ownership of the single shield QSPI flash between the XIP read-only controller (default owner) and the normal read-write QSPI controller used for flash programming. It drives the `qspi_sel` input of the DAPLink/Arty shield mux. Ownership changes only after the current owner's slave select has been idle for a guard interval. A hold output stalls the XIP bus bridge while the read-write side owns the flash, so the mux never switches mid-transaction.

## Interface
- `GUARD_CYCLES`, default 4: consecutive idle-SS cycles required before a switch, and the minimum XIP dwell time; legal range ≥ 1.
- `TIMEOUT_CYCLES`, default 65535: read-write idle limit; used only when the timeout feature is compiled in; legal range ≥ 2.
---
- `ext_spi_clk` — in — 1 — QSPI clock; the only clock.
- `ext_spi_rst` — in — 1 — reset; synchronous, active-high.
- `rw_req` — in — 1 — level request for flash ownership from the read-write side, driven by a software register.
- `rw_gnt` — out — 1 — read-write controller owns the flash and may assert `qspi_ss_o`.
- `qspi_xip_ss_o` — in — 1 — XIP controller slave select, active-low (high = idle).
- `qspi_ss_o` — in — 1 — read-write controller slave select, active-low.
- `qspi_sel` — out — 1 — mux select: 0 = XIP, 1 = read-write.
- `xip_hold` — out — 1 — stall new XIP bus accesses.
- `timeout_flag` — out — 1 — sticky flag: ownership was revoked by timeout.
- `timeout_clr` — in — 1 — clears `timeout_flag`; single-cycle pulse.

## Operation
- All outputs are registered.
- Reset values: state S_XIP, `qspi_sel`=0, `rw_gnt`=0, `xip_hold`=0, `timeout_flag`=0, idle counter 0, dwell counter saturated at `GUARD_CYCLES`.
- Reset is authoritative mid-operation: the arbiter returns to S_XIP on the next edge regardless of SS state. Both QSPI peripherals share this reset.
- **S_XIP**: `sel`=0, `hold`=0, `gnt`=0.
  - The dwell counter increments and saturates at `GUARD_CYCLES`.
  - `rw_req`=1 with dwell saturated → S_XIP_DRAIN.
  - `rw_req` arriving with dwell not saturated is held off until dwell saturates.
- **S_XIP_DRAIN**: `hold`=1, `sel`=0, `gnt`=0.
  - Idle counter: `qspi_xip_ss_o`=0 → clear to 0; `qspi_xip_ss_o`=1 with count = `GUARD_CYCLES`-1 → S_RW; otherwise increment.
  - `rw_req`=0 → S_XIP (abort); the dwell counter is not cleared.
- **S_RW**: `sel`=1, `gnt`=1, `hold`=1.
  - `rw_req`=0 → S_RW_DRAIN.
- **S_RW_DRAIN**: `sel`=1, `gnt`=0, `hold`=1.
  - Same idle counting, on `qspi_ss_o`.
  - Terminal count → S_XIP with the dwell counter cleared to 0.
  - `rw_req` is ignored in this state; a re-request is served only after the XIP dwell completes (anti-starvation).
- The idle counter clears on every state entry.
- **Simultaneous events**:
  - Terminal idle count and `rw_req` dropping in S_XIP_DRAIN → abort wins; go to S_XIP.
  - `timeout_clr` coincident with a timeout event → the flag sets (set wins).

## Timing
- `rw_req` rising with XIP idle and dwell saturated:
  - `xip_hold` high 1 edge later.
  - `qspi_sel` and `rw_gnt` high `GUARD_CYCLES`+1 edges after the first sampling edge (5 cycles at default).
- `rw_req` falling with `qspi_ss_o` idle:
  - `rw_gnt` low 1 edge later.
  - `qspi_sel` and `xip_hold` low `GUARD_CYCLES`+1 edges later.
- Any SS low cycle during a drain restarts the full guard interval.
- `qspi_sel` never toggles while either SS input is low.
- Worst-case drain latency is unbounded if the XIP SS is held low; software polls `rw_gnt`.

## Configuration
- **`QSPI_ARB_TIMEOUT_EN` defined**:
  - In S_RW, a second idle counter counts consecutive cycles with `qspi_ss_o`=1 and clears on `qspi_ss_o`=0.
  - Reaching `TIMEOUT_CYCLES` → S_RW_DRAIN and sets `timeout_flag`.
  - A new request is then accepted only after `rw_req` has been seen low at least one cycle (re-arm).
- **Not defined**: no timeout counter, S_RW is left only via `rw_req`=0, `timeout_flag` is tied 0, and `timeout_clr` is unused.

## Structure
- **Shared package `qspi_arb_pkg`**: state enum (S_XIP, S_XIP_DRAIN, S_RW, S_RW_DRAIN), counter width functions (`$clog2`-based), and the SS idle level constant.
- **Sub-module `qspi_idle_counter`**:
  - Parameterised consecutive-idle counter with clear, enable, and terminal-count output.
  - Instantiated once for guard and dwell counting, and once more when `QSPI_ARB_TIMEOUT_EN` is defined.

## Test plan
- Reset, then hold `rw_req`=1 with both SS high → `xip_hold` high at edge 1; `qspi_sel`=1 and `rw_gnt`=1 at edge 5; `rw_req`=0 → `rw_gnt` low at edge 1, `qspi_sel`=0 at edge 5.
- In S_XIP_DRAIN, pulse `qspi_xip_ss_o` low for 3 cycles after 2 idle cycles → grant delayed until 4 further consecutive idle cycles; `qspi_sel` never changes while SS is low.
- Drop `rw_req` on the cycle the guard count terminates → returns to S_XIP, `qspi_sel` stays 0, `xip_hold` drops on the next edge.
- Release ownership, then re-assert `rw_req` immediately → `xip_hold` stays low for ≥ 4 cycles in S_XIP before dropping into S_XIP_DRAIN.
- With `QSPI_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, hold `rw_req`=1 with `qspi_ss_o` idle → `rw_gnt` drops after 16 idle cycles and `timeout_flag`=1; no re-grant until `rw_req` toggles; `timeout_clr` clears the flag.
- Assert `ext_spi_rst` in S_RW with `qspi_ss_o` low → next edge: `qspi_sel`=0, `rw_gnt`=0, `xip_hold`=0, `timeout_flag`=0.

Source files
------------

// File: rtl/qspi_arb_pkg.sv
// rtl/qspi_arb_pkg.sv - shared state type, counter sizing and SS idle level for the QSPI owner arbiter
package qspi_arb_pkg;

    typedef enum logic [1:0] {
        S_XIP,
        S_XIP_DRAIN,
        S_RW,
        S_RW_DRAIN
    } arb_state_e;

    localparam logic SS_IDLE = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/qspi_owner_arbiter_if.sv
// rtl/qspi_owner_arbiter_if.sv - request/grant, slave-select and mux-select bundle of the QSPI owner arbiter
interface qspi_owner_arbiter_if;

    logic rw_req;
    logic rw_gnt;
    logic qspi_xip_ss_o;
    logic qspi_ss_o;
    logic qspi_sel;
    logic xip_hold;
    logic timeout_flag;
    logic timeout_clr;

    modport master (
        output rw_req, qspi_xip_ss_o, qspi_ss_o, timeout_clr,
        input  rw_gnt, qspi_sel, xip_hold, timeout_flag
    );

    modport slave (
        input  rw_req, qspi_xip_ss_o, qspi_ss_o, timeout_clr,
        output rw_gnt, qspi_sel, xip_hold, timeout_flag
    );

endinterface

// File: rtl/qspi_idle_counter.sv
// rtl/qspi_idle_counter.sv - saturating consecutive-cycle counter with clear, enable and terminal count
module qspi_idle_counter
    import qspi_arb_pkg::*;
#(
    parameter int unsigned LIMIT     = 4,
    parameter bit          RESET_SAT = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o,
    output logic sat_o
);

    localparam int unsigned W = cnt_width(LIMIT);
    localparam logic [W-1:0] LIM    = W'(LIMIT);
    localparam logic [W-1:0] LIM_M1 = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= RESET_SAT ? LIM : '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && cnt_q != LIM) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // tc fires on the cycle whose increment would reach LIMIT
    assign tc_o  = en_i && (cnt_q == LIM_M1);
    assign sat_o = (cnt_q == LIM);

endmodule

// File: rtl/qspi_owner_arbiter.sv
// rtl/qspi_owner_arbiter.sv - XIP / read-write ownership arbiter for the shield QSPI mux; QSPI_ARB_TIMEOUT_EN adds a read-write idle timeout
module qspi_owner_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  ext_spi_clk,
    input  logic                  ext_spi_rst,
    qspi_owner_arbiter_if.slave   bus
);

    arb_state_e state_q;
    logic       sel_q, gnt_q, hold_q;
    logic       in_drain, drain_idle;
    logic       guard_tc, guard_sat_unused;
    logic       dwell_sat, dwell_tc_unused;
    logic       timeout_hit, req_ok;

    assign in_drain   = (state_q == S_XIP_DRAIN) || (state_q == S_RW_DRAIN);
    assign drain_idle = ((state_q == S_XIP_DRAIN) ? bus.qspi_xip_ss_o : bus.qspi_ss_o) == SS_IDLE;

    // held at zero outside the drain states, so every state entry starts a fresh guard interval
    qspi_idle_counter #(.LIMIT(GUARD_CYCLES)) u_guard (
        .clk_i (ext_spi_clk),
        .rst_i (ext_spi_rst),
        .clr_i (!in_drain || !drain_idle),
        .en_i  (in_drain && drain_idle),
        .tc_o  (guard_tc),
        .sat_o (guard_sat_unused)
    );

    // an aborted XIP drain keeps the accumulated dwell; only a read-write tenure resets it
    qspi_idle_counter #(.LIMIT(GUARD_CYCLES), .RESET_SAT(1'b1)) u_dwell (
        .clk_i (ext_spi_clk),
        .rst_i (ext_spi_rst),
        .clr_i ((state_q == S_RW) || (state_q == S_RW_DRAIN)),
        .en_i  (state_q == S_XIP),
        .tc_o  (dwell_tc_unused),
        .sat_o (dwell_sat)
    );

`ifdef QSPI_ARB_TIMEOUT_EN
    logic rw_idle, to_sat_unused, flag_q, rearm_q;

    assign rw_idle = (bus.qspi_ss_o == SS_IDLE);

    qspi_idle_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk_i (ext_spi_clk),
        .rst_i (ext_spi_rst),
        .clr_i ((state_q != S_RW) || !rw_idle),
        .en_i  ((state_q == S_RW) && rw_idle),
        .tc_o  (timeout_hit),
        .sat_o (to_sat_unused)
    );

    always_ff @(posedge ext_spi_clk) begin
        if (ext_spi_rst) begin
            flag_q  <= 1'b0;
            rearm_q <= 1'b0;
        end else if (timeout_hit) begin
            flag_q  <= 1'b1;
            rearm_q <= 1'b1;
        end else begin
            if (bus.timeout_clr) flag_q  <= 1'b0;
            if (!bus.rw_req)     rearm_q <= 1'b0;
        end
    end

    assign req_ok           = bus.rw_req && !rearm_q;
    assign bus.timeout_flag = flag_q;
`else
    logic unused_timeout;

    assign timeout_hit      = 1'b0;
    assign req_ok           = bus.rw_req;
    assign bus.timeout_flag = 1'b0;
    assign unused_timeout   = bus.timeout_clr ^ (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge ext_spi_clk) begin
        if (ext_spi_rst) begin
            state_q <= S_XIP;
            sel_q   <= 1'b0;
            gnt_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            case (state_q)
                S_XIP: begin
                    if (req_ok && dwell_sat) begin
                        state_q <= S_XIP_DRAIN;
                        hold_q  <= 1'b1;
                    end
                end
                S_XIP_DRAIN: begin
                    if (!bus.rw_req) begin
                        state_q <= S_XIP;
                        hold_q  <= 1'b0;
                    end else if (guard_tc) begin
                        state_q <= S_RW;
                        sel_q   <= 1'b1;
                        gnt_q   <= 1'b1;
                    end
                end
                S_RW: begin
                    if (timeout_hit || !bus.rw_req) begin
                        state_q <= S_RW_DRAIN;
                        gnt_q   <= 1'b0;
                    end
                end
                S_RW_DRAIN: begin
                    if (guard_tc) begin
                        state_q <= S_XIP;
                        sel_q   <= 1'b0;
                        hold_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_XIP;
                    sel_q   <= 1'b0;
                    gnt_q   <= 1'b0;
                    hold_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.qspi_sel = sel_q;
    assign bus.rw_gnt   = gnt_q;
    assign bus.xip_hold = hold_q;

endmodule
